apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter.sv | 154 +++++++++++++++
 tb/tb_apb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-master round-robin front end driving a single APB requester port, with
// an optional PREADY timeout that completes a stuck transfer with an error.
module apb_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    output logic [1:0]  dbg_state
);

    // Handshake: mN_req is a level held by the master until its one-cycle
    // mN_done; the APB side follows SETUP/ACCESS with PREADY sampled only in ACCESS.

    localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          prio_q, prio_d;
    logic          err_q, err_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [31:0]   m0_rdata_q, m0_rdata_d;
    logic [31:0]   m1_rdata_q, m1_rdata_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] tcnt_inc;
    logic          win;

    // A lone requester wins; on contention the priority pointer decides.
    assign win      = (m0_req && m1_req) ? prio_q : m1_req;
    assign tcnt_inc = tcnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_d     = prio_q;
        err_d      = err_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d  = SETUP;
                    grant_d  = win;
                    err_d    = 1'b0;
                    pwrite_d = win ? m1_write : m0_write;
                    paddr_d  = win ? m1_addr  : m0_addr;
                    pwdata_d = win ? m1_wdata : m0_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                tcnt_d  = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d = DONE;
                    prio_d  = ~grant_q;
                    if (!pwrite_q) begin
                        if (grant_q) m1_rdata_d = PRDATA;
                        else         m0_rdata_d = PRDATA;
                    end
                end else if (TIMEOUT > 0) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == TIMEOUT_C) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        prio_d  = ~grant_q;
                        if (grant_q) m1_rdata_d = 32'h0;
                        else         m0_rdata_d = 32'h0;
                    end
                end
            end
            DONE: begin
                // No grant here: a master dropping req after done must not be re-served.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            prio_q     <= 1'b0;
            err_q      <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 32'h0;
            pwdata_q   <= 32'h0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_q     <= prio_d;
            err_q      <= err_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_done   = (state_q == DONE) && !grant_q;
    assign m1_done   = (state_q == DONE) && grant_q;
    assign m0_err    = m0_done && err_q;
    assign m1_err    = m1_done && err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: vector table of single-master transfers, hand-written
// sequences for latency, contention, timeout and mid-transfer reset.
module tb_apb_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [1:0]  dbg_state;

    apb_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];       // {master, err, rdata}
    int          slave_waits = 0;
    logic [31:0] slave_prdata = 32'h0;

    typedef struct {
        logic        m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // APB slave: PREADY after slave_waits low ACCESS cycles; noise outside ACCESS.
    initial begin : slave
        int acc_cnt;
        acc_cnt = 0;
        PREADY  = 1'b0;
        PRDATA  = 32'h0;
        forever begin
            @(negedge clk);
            if (PSEL && PENABLE) begin
                PREADY = (acc_cnt >= slave_waits);
                PRDATA = slave_prdata;
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                PREADY  = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
            end
        end
    end

    // Scoreboard: every done pulse pops one expected completion.
    initial begin : monitor
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m0_err && !m0_done) chk("m0_err_without_done", 32'(m0_err), 32'd0);
                if (m1_err && !m1_done) chk("m1_err_without_done", 32'(m1_err), 32'd0);
                if (m0_done && m1_done) begin
                    chk("two_done_pulses", 32'd2, 32'd1);
                end else if (m0_done || m1_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(m1_done), 32'(m0_done));
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_master", 32'(m1_done), 32'(e[33]));
                        chk("done_err", 32'(m1_done ? m1_err : m0_err), 32'(e[32]));
                        chk("done_rdata", m1_done ? m1_rdata : m0_rdata, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_txn(input logic m, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] prdata, input int waits,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic got;
        got = 1'b0;
        @(negedge clk);
        if (m) begin
            m1_req = 1'b1; m1_write = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_write = wr; m0_addr = addr; m0_wdata = wdata;
        end
        slave_waits  = waits;
        slave_prdata = prdata;
        exp_q.push_back({m, exp_err, exp_rdata});
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (PSEL) begin
                chk("paddr_hold", PADDR, addr);
                chk("pwdata_hold", PWDATA, wdata);
                chk("pwrite_hold", 32'(PWRITE), 32'(wr));
            end
            if (m ? m1_done : m0_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("txn_done_seen", 32'(got), 32'd1);
        if (m) m1_req = 1'b0;
        else   m0_req = 1'b0;
    endtask

    initial begin : stim
        int n_done;
        int acc;
        logic got;

        rst = 1'b1;
        m0_req = 1'b0; m0_write = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_write = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_done", 32'({m0_done, m1_done, m0_err, m1_err}), 32'd0);
        rst = 1'b0;

        // Minimum-latency read on master 0
        @(negedge clk);
        m0_req = 1'b1; m0_write = 1'b0; m0_addr = 32'h4000_0004; m0_wdata = 32'h0;
        slave_waits = 0; slave_prdata = 32'h1234_5678;
        exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
        @(negedge clk);
        chk("lat_c1_state", 32'(dbg_state), 32'(S_SETUP));
        chk("lat_c1_psel_pen", 32'({PSEL, PENABLE}), 32'b10);
        chk("lat_c1_paddr", PADDR, 32'h4000_0004);
        @(negedge clk);
        chk("lat_c2_state", 32'(dbg_state), 32'(S_ACCESS));
        chk("lat_c2_psel_pen", 32'({PSEL, PENABLE}), 32'b11);
        @(negedge clk);
        chk("lat_c3_m0_done", 32'(m0_done), 32'd1);
        chk("lat_c3_m0_err", 32'(m0_err), 32'd0);
        chk("lat_c3_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("lat_c3_psel_pen", 32'({PSEL, PENABLE}), 32'b00);
        m0_req = 1'b0;
        @(negedge clk);
        chk("lat_c4_state", 32'(dbg_state), 32'(S_IDLE));

        // Table of single-master transfers; expectations follow from the order
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 32'hFFFF_0000, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 15, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_2222, 32'hFFFF_0000, 16, 32'h0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h0000_1111, 20, 32'h0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h2222_3333, 0, 32'h2222_3333, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0700, 32'h3333_4444, 32'hFFFF_0000, 2, 32'h0, 1'b0};
        vecs[7].m = 1'b0; vecs[7].wr = 1'b0; vecs[7].addr = $urandom; vecs[7].wdata = $urandom;
        vecs[7].prdata = $urandom; vecs[7].waits = $urandom_range(0, 5);
        vecs[7].exp_rdata = vecs[7].prdata; vecs[7].exp_err = 1'b0;
        vecs[8].m = 1'b1; vecs[8].wr = 1'b1; vecs[8].addr = $urandom; vecs[8].wdata = $urandom;
        vecs[8].prdata = $urandom; vecs[8].waits = $urandom_range(0, 5);
        vecs[8].exp_rdata = 32'h2222_3333; vecs[8].exp_err = 1'b0;
        for (int i = 0; i < 9; i++)
            do_txn(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata,
                   vecs[i].waits, vecs[i].exp_rdata, vecs[i].exp_err);

        // Contention from reset: m0, m1, m0
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_write = 1'b0; m0_addr = 32'h0000_1000;
        m1_req = 1'b1; m1_write = 1'b0; m1_addr = 32'h0000_2000;
        slave_waits = 0; slave_prdata = 32'h0BAD_F00D;
        exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
        exp_q.push_back({1'b1, 1'b0, 32'h0BAD_F00D});
        exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
        n_done = 0;
        for (int i = 0; i < 100 && n_done < 3; i++) begin
            @(negedge clk);
            if (m0_done || m1_done) n_done++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_done_count", 32'(n_done), 32'd3);
        repeat (4) @(negedge clk);
        chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);

        // Stuck PREADY: timeout after exactly 16 ACCESS cycles, then normal grant
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_write = 1'b0; m0_addr = 32'h0000_3000;
        slave_waits = 1000; slave_prdata = 32'h7777_7777;
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        acc = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (PSEL && PENABLE) acc++;
            if (m0_done) begin
                got = 1'b1;
                break;
            end
        end
        m0_req = 1'b0;
        chk("to_done_seen", 32'(got), 32'd1);
        chk("to_access_cycles", 32'(acc), 32'd16);
        do_txn(1'b1, 1'b0, 32'h0000_3004, 32'h0, 32'h1357_2468, 0, 32'h1357_2468, 1'b0);

        // Reset in the middle of ACCESS
        do_txn(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'h5A5A_5A5A, 0, 32'h5A5A_5A5A, 1'b0);
        @(negedge clk);
        m1_req = 1'b1; m1_write = 1'b1; m1_addr = 32'h8000_0010; m1_wdata = 32'h7777_7777;
        slave_waits = 1000;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (PSEL && PENABLE) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_access", 32'(got), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        m1_req = 1'b0;
        @(negedge clk);
        chk("rstmid_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rstmid_ctrl", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
        chk("rstmid_paddr", PADDR, 32'h0);
        chk("rstmid_pwdata", PWDATA, 32'h0);
        chk("rstmid_m0_rdata", m0_rdata, 32'h0);
        chk("rstmid_m1_rdata", m1_rdata, 32'h0);
        chk("rstmid_done_err", 32'({m0_done, m1_done, m0_err, m1_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_no_done", 32'({m0_done, m1_done}), 32'd0);
        do_txn(1'b1, 1'b0, 32'h0000_5000, 32'h0, 32'h2468_1357, 0, 32'h2468_1357, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
